mux_sel_sequencer: RTL and testbench
====================================

Name: mux_sel_sequencer

Overview:
- Drives one 8:1 multiplexer (`multiplexer8_1`) from the upstream side.
- Accepts an 8-bit parallel word over a valid/ready handshake and presents it on the mux data inputs.
- Steps the 3-bit select through all 8 channels, samples the mux output on each step and emits a serial bit stream plus an end-of-word pulse.
- Turns the combinational mux into a parallel-to-serial stage.

Parameters:
- HOLD_CYCLES, 1, clock cycles each select value is held before the mux output is sampled; legal range 1..255, 0 is illegal (elaboration assertion).
- SCAN_DOWN, 0, 0 = scan x0..x7 (sel 0→7); 1 = scan x7..x0 (sel 7→0).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid_i  input  1  parallel word valid.
- in_data_i  input  8  parallel word; bit k drives mux input xk.
- in_ready_o  output  1  block can accept a word.
- mux_x_o  output  8  to mux x0..x7 (bit k → xk).
- mux_s_o  output  3  to mux {s2,s1,s0}.
- mux_y_i  input  1  mux output y.
- ser_bit_o  output  1  sampled serial bit.
- ser_valid_o  output  1  ser_bit_o valid, one-cycle pulse per bit.
- done_o  output  1  one-cycle pulse with the last bit of a word.
- err_o  output  1  sticky mismatch flag (optional feature only).

Behaviour:
- One clock domain. Reset is synchronous and active-low, named rst_n, sampled on the clk rising edge.
- Reset values: state = IDLE, in_ready_o = 1 (after reset), mux_x_o = 0, mux_s_o = 0, ser_bit_o = 0, ser_valid_o = 0, done_o = 0, err_o = 0.
- States: IDLE, SCAN, LAST.
- IDLE:
  - in_ready_o = 1.
  - On in_valid_i & in_ready_o: mux_x_o <= in_data_i; mux_s_o <= 0 (SCAN_DOWN = 0) or 7 (SCAN_DOWN = 1); hold counter <= 0; step counter <= 0; go to SCAN.
- SCAN:
  - in_ready_o = 0; in_valid_i is ignored and mux_x_o stays stable.
  - Hold counter increments each cycle.
  - When hold counter = HOLD_CYCLES-1:
    - ser_bit_o <= mux_y_i, ser_valid_o <= 1 next cycle.
    - Hold counter <= 0.
    - mux_s_o steps ±1 (3-bit wrap never occurs within a word).
    - Step counter increments.
    - If step counter = 7, go to LAST instead of stepping.
- LAST:
  - ser_valid_o = 1 carrying bit 8, done_o = 1.
  - mux_s_o returns to its start value.
  - Next state IDLE unconditionally. No back-to-back accept in LAST.
- Sampling rule: y is sampled on the last hold cycle of each select value, so mux_s_o has been stable ≥ HOLD_CYCLES cycles.
- Latency for HOLD_CYCLES = 1, accept at cycle 0:
  - mux_s_o = 0..7 in cycles 1..8.
  - ser_valid_o in cycles 2..9.
  - done_o in cycle 9.
  - in_ready_o = 1 again in cycle 10.
- General latency: done_o at cycle 8·HOLD_CYCLES+1.
- Reset mid-word: at the next edge, everything takes its reset value and the partial word is discarded; no done_o pulse.
- mux_x_o is cleared to 0 only by reset; it holds the last word while idle.

Optional Feature:
- Macro: MUX_SEL_SEQUENCER_CHECK_EN.
- Defined:
  - At each sample, compare mux_y_i against mux_x_o[mux_s_o].
  - On mismatch set err_o (sticky); it is cleared on the next accepted word or on reset.
- Undefined: err_o is tied to 0 and no compare logic is built.

Decomposition:
- Package mux_sel_seq_pkg:
  - N_IN = 8.
  - SEL_W = 3.
  - State typedef (IDLE, SCAN, LAST).
  - Select start/end constants derived from SCAN_DOWN.
- One sub-module: mux_sel_hold_timer, the parameterised HOLD_CYCLES counter producing a one-cycle sample strobe.
- Top-level owns the FSM, select stepping and output registers.
- Bench instantiates the real 8:1 mux between mux_x_o/mux_s_o and mux_y_i.

Test Plan:
- Reset, HOLD=1, word 8'hA5 accepted at cycle 0 → ser_bit_o = 1,0,1,0,0,1,0,1 in cycles 2..9; done_o at 9; in_ready_o = 1 at 10.
- SCAN_DOWN=1, word 8'h01 → mux_s_o sequence 7..0; serial 0,0,0,0,0,0,0,1; done_o with final 1.
- HOLD=3, word 8'hFF → each mux_s_o value held 3 cycles; 8 ser_valid_o pulses spaced 3 cycles; done_o at cycle 25.
- in_valid_i held high with 8'h3C during a scan of 8'hC3 → second word not accepted until cycle 10; serial output equals 8'hC3's bits.
- rst_n low at cycle 4 of a scan → cycle 5: all outputs at reset values, no done_o; next word scans normally.
- CHECK_EN: force mux_y_i = 0 while bit 2 of 8'h04 is sampled → err_o = 1 and stays; clears on next accept.

Source files
------------

// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and constants for the mux select sequencer.
// Select start/end values follow the scan direction.
package mux_sel_seq_pkg;

  localparam int N_IN  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    LAST
  } state_t;

  function automatic logic [SEL_W-1:0] sel_start(
    input bit down
  );
    return down ? SEL_W'(N_IN - 1) : '0;
  endfunction

  function automatic logic [SEL_W-1:0] sel_end(
    input bit down
  );
    return down ? '0 : SEL_W'(N_IN - 1);
  endfunction

endpackage

// File: rtl/mux_sel_sequencer_hold_timer.sv
// Counts HOLD_CYCLES per select value and emits
// a one-cycle sample strobe on the last hold cycle.
module mux_sel_hold_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic strobe_o
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..255");
  end

  localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign strobe_o = en_i && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = strobe_o ? '0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Parallel-to-serial driver for an external 8:1 mux.
// Optional y-vs-x self check: MUX_SEL_SEQUENCER_CHECK_EN.
module mux_sel_sequencer
  import mux_sel_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int SCAN_DOWN   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [N_IN-1:0]  in_data_i,
  output logic             in_ready_o,
  output logic [N_IN-1:0]  mux_x_o,
  output logic [SEL_W-1:0] mux_s_o,
  input  logic             mux_y_i,
  output logic             ser_bit_o,
  output logic             ser_valid_o,
  output logic             done_o,
  output logic             err_o
);

  localparam bit DOWN = (SCAN_DOWN != 0);
  localparam logic [SEL_W-1:0] S_START = sel_start(DOWN);
  localparam logic [SEL_W-1:0] S_END   = sel_end(DOWN);

  state_t           state_q;
  logic             ready_q;
  logic [N_IN-1:0]  x_q;
  logic [SEL_W-1:0] s_q;
  logic [SEL_W-1:0] step_q;
  logic             bit_q;
  logic             sv_q;
  logic             done_q;
  logic             accept;
  logic             strobe;

  assign accept = (state_q == IDLE) && in_valid_i && ready_q;

  mux_sel_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (accept),
    .en_i    (state_q == SCAN),
    .strobe_o(strobe)
  );

`ifdef MUX_SEL_SEQUENCER_CHECK_EN
  logic err_q;
  logic miss;

  assign miss  = (mux_y_i != x_q[s_q]);
  assign err_o = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (state_q == SCAN && strobe && miss) begin
      err_q <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      x_q     <= '0;
      s_q     <= '0;
      step_q  <= '0;
      bit_q   <= 1'b0;
      sv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sv_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            x_q     <= in_data_i;
            s_q     <= S_START;
            step_q  <= '0;
            ready_q <= 1'b0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (strobe) begin
            bit_q <= mux_y_i;
            sv_q  <= 1'b1;
            // Last channel: keep the select, finish in LAST.
            if (step_q == SEL_W'(N_IN - 1)) begin
              done_q  <= 1'b1;
              state_q <= LAST;
            end else begin
              step_q <= step_q + 1'b1;
              s_q    <= DOWN ? s_q - 1'b1 : s_q + 1'b1;
            end
          end
        end
        LAST: begin
          s_q     <= S_START;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  logic unused_end;
  assign unused_end = ^S_END;

  assign in_ready_o  = ready_q;
  assign mux_x_o     = x_q;
  assign mux_s_o     = s_q;
  assign ser_bit_o   = bit_q;
  assign ser_valid_o = sv_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Three sequencer configurations, each driving its own
// 8:1 mux, checked against a cycle-arithmetic model.
module tb_mux_sel_sequencer;

`ifdef MUX_SEL_SEQUENCER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       vld [3];
  logic [7:0] din [3];
  logic       rdy [3];
  logic [7:0] x   [3];
  logic [2:0] s   [3];
  logic       y   [3];
  logic       sb  [3];
  logic       sv  [3];
  logic       dn  [3];
  logic       er  [3];
  logic       fz  [3];

  int         n_chk;
  int         n_err;
  logic       err_m [3];
  logic [7:0] last_w [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int H = (g == 2) ? 3 : 1;
    localparam int D = (g == 1) ? 1 : 0;

    mux_sel_sequencer #(
      .HOLD_CYCLES(H),
      .SCAN_DOWN  (D)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (vld[g]),
      .in_data_i  (din[g]),
      .in_ready_o (rdy[g]),
      .mux_x_o    (x[g]),
      .mux_s_o    (s[g]),
      .mux_y_i    (y[g]),
      .ser_bit_o  (sb[g]),
      .ser_valid_o(sv[g]),
      .done_o     (dn[g]),
      .err_o      (er[g])
    );

    // 8:1 mux; fz pins channel 2 low to inject a fault.
    assign y[g] = (fz[g] && s[g] == 3'd2) ? 1'b0
                                          : x[g][s[g]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hold_of(input int g);
    return (g == 2) ? 3 : 1;
  endfunction

  function automatic bit down_of(input int g);
    return (g == 1);
  endfunction

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_rdy", rdy[g], 1);
      chk("idle_sv", sv[g], 0);
      chk("idle_done", dn[g], 0);
      chk("idle_x", x[g], last_w[g]);
      chk("idle_err", er[g], err_m[g]);
      tick();
    end
  endtask

  // Accept w at edge E0, then check cycles 1..8H+2.
  task automatic run_word(input int g,
                          input logic [7:0] w,
                          input bit keep,
                          input logic [7:0] nxt);
    int h;
    bit dw;
    int t;
    int idx;
    int b;
    int ch;
    logic eb;
    bit ev;
    h  = hold_of(g);
    dw = down_of(g);
    t  = 0;
    while (!rdy[g] && t < 64) begin
      tick();
      t++;
    end
    chk("rdy_wait", rdy[g], 1);
    vld[g] = 1'b1;
    din[g] = w;
    tick();
    if (keep) din[g] = nxt;
    else vld[g] = 1'b0;
    err_m[g]  = 1'b0;
    last_w[g] = w;
    for (int c = 1; c <= 8 * h + 2; c++) begin
      idx = (c - 1) / h;
      chk("ready", rdy[g], (c >= 8 * h + 2) ? 1 : 0);
      chk("x_hold", x[g], w);
      if (c <= 8 * h)
        chk("sel", s[g], dw ? 7 - idx : idx);
      else if (c == 8 * h + 1)
        chk("sel_end", s[g], dw ? 0 : 7);
      else
        chk("sel_ret", s[g], dw ? 7 : 0);
      ev = (c >= h + 1) && ((c - 1) % h == 0)
           && (c <= 8 * h + 1);
      chk("ser_valid", sv[g], ev ? 1 : 0);
      if (ev) begin
        b  = (c - 1) / h - 1;
        ch = dw ? 7 - b : b;
        eb = (fz[g] && ch == 2) ? 1'b0 : w[ch];
        chk("ser_bit", sb[g], eb);
        if (CHK && eb != w[ch]) err_m[g] = 1'b1;
      end
      chk("done", dn[g], (c == 8 * h + 1) ? 1 : 0);
      chk("err", er[g], err_m[g]);
      if (c < 8 * h + 2) tick();
    end
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    tick();
    tick();
    for (int g = 0; g < 3; g++) begin
      chk("rst_rdy", rdy[g], 1);
      chk("rst_x", x[g], 0);
      chk("rst_s", s[g], 0);
      chk("rst_bit", sb[g], 0);
      chk("rst_sv", sv[g], 0);
      chk("rst_done", dn[g], 0);
      chk("rst_err", er[g], 0);
      err_m[g]  = 1'b0;
      last_w[g] = 8'h00;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    logic [7:0] nw;
    int g;
    bit kp;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld[i]    = 1'b0;
      din[i]    = 8'h00;
      fz[i]     = 1'b0;
      err_m[i]  = 1'b0;
      last_w[i] = 8'h00;
    end
    reset_all();
    idle(0, 2);

    run_word(0, 8'hA5, 1'b0, 8'h00);
    run_word(1, 8'h01, 1'b0, 8'h00);
    run_word(2, 8'hFF, 1'b0, 8'h00);
    run_word(0, 8'hC3, 1'b1, 8'h3C);
    run_word(0, 8'h3C, 1'b0, 8'h00);
    idle(0, 2);

    // Reset asserted during cycle 4 of a scan.
    vld[0] = 1'b1;
    din[0] = 8'h96;
    tick();
    vld[0] = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("mrst_rdy", rdy[i], 1);
      chk("mrst_x", x[i], 0);
      chk("mrst_s", s[i], 0);
      chk("mrst_bit", sb[i], 0);
      chk("mrst_sv", sv[i], 0);
      chk("mrst_done", dn[i], 0);
      chk("mrst_err", er[i], 0);
      err_m[i]  = 1'b0;
      last_w[i] = 8'h00;
    end
    rst_n = 1'b1;
    tick();
    idle(0, 10);
    run_word(0, 8'h5A, 1'b0, 8'h00);

    if (CHK) begin
      fz[0] = 1'b1;
      run_word(0, 8'h04, 1'b0, 8'h00);
      fz[0] = 1'b0;
      idle(0, 3);
      run_word(0, 8'h81, 1'b0, 8'h00);
      fz[2] = 1'b1;
      run_word(2, 8'hFB, 1'b0, 8'h00);
      fz[2] = 1'b0;
      idle(2, 2);
    end

    for (int it = 0; it < 24; it++) begin
      g  = $urandom_range(0, 2);
      w  = 8'($urandom);
      nw = 8'($urandom);
      kp = ($urandom_range(0, 3) == 0);
      run_word(g, w, kp, nw);
      if (kp) run_word(g, nw, 1'b0, 8'h00);
      idle(g, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
